// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: one-entry holding register with saturation to the
// slot width, self-generated BCLK/LRCLK, and the same word sent on left and right.
module i2s_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned IN_WIDTH  = 17,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [IN_WIDTH-1:0] sample,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       i2s_bclk,
    output logic                       i2s_lrclk,
    output logic                       i2s_data,
    output logic                       frame_start,
    output logic                       underrun
);

    localparam int unsigned FRAME_BITS = 2 * OUT_WIDTH;
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0]     DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST    = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0]     RIGHT_FIRST = BIT_W'(OUT_WIDTH);
    localparam logic [OUT_WIDTH-1:0] SAT_POS     = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_NEG     = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [DIV_W-1:0]            div_cnt;
    logic [BIT_W-1:0]            bit_cnt;
    logic [BIT_W-1:0]            next_bit;
    logic                        tick;
    logic                        fall;
    logic                        load;
    logic                        accept;
    logic [OUT_WIDTH-1:0]        hold;
    logic                        hold_full;
    logic [OUT_WIDTH-1:0]        last_word;
    logic [OUT_WIDTH-1:0]        slot_word;
    logic [FRAME_BITS-1:0]       shreg;
    logic [IN_WIDTH-OUT_WIDTH:0] sign_bits;
    logic [OUT_WIDTH-1:0]        sat;

    // In range exactly when every bit above the slot's sign bit matches it.
    always_comb begin
        sign_bits = sample[IN_WIDTH-1:OUT_WIDTH-1];
        if ((&sign_bits) || !(|sign_bits)) begin
            sat = sample[OUT_WIDTH-1:0];
        end else if (sample[IN_WIDTH-1]) begin
            sat = SAT_NEG;
        end else begin
            sat = SAT_POS;
        end
    end

    always_comb begin
        tick      = en && (div_cnt == DIV_LAST);
        fall      = tick && i2s_bclk;
        next_bit  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        load      = fall && (bit_cnt == BIT_LAST);
        accept    = sample_valid && !hold_full;
        slot_word = hold_full ? hold : last_word;
    end

    assign sample_ready = !hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                i2s_bclk <= !i2s_bclk;
            end
        end
    end

    // The shift register's MSB is always the next bit to drive, so after 31 shifts
    // it holds the old right-channel LSB exactly when the new word is loaded; that
    // gives the one-BCLK I2S data delay without a separate delay stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= BIT_LAST;
            i2s_lrclk <= 1'b1;
            i2s_data  <= 1'b0;
            shreg     <= '0;
        end else if (fall) begin
            bit_cnt   <= next_bit;
            i2s_lrclk <= (next_bit >= RIGHT_FIRST);
            i2s_data  <= shreg[FRAME_BITS-1];
            if (load) begin
                shreg <= {slot_word, slot_word};
            end else begin
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            last_word <= '0;
        end else begin
            if (load && hold_full) begin
                last_word <= hold;
            end
            if (accept) begin
                hold      <= sat;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load && !hold_full;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a timing/queue model derived from enabled-cycle counts, checked
// every cycle, plus directed scenarios with hand-computed slot words and cycle numbers.
module tb_i2s_tx;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned IN_WIDTH   = 17;
    localparam int unsigned OUT_WIDTH  = 16;
    localparam int          FRAME_BITS = 32;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       en = 1'b1;
    logic signed [IN_WIDTH-1:0] sample = '0;
    logic                       sample_valid = 1'b0;
    logic                       sample_ready;
    logic                       i2s_bclk;
    logic                       i2s_lrclk;
    logic                       i2s_data;
    logic                       frame_start;
    logic                       underrun;

    i2s_tx #(
        .CLK_DIV  (CLK_DIV),
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: everything follows from e = enabled cycles since reset.
    int          e = 0;
    bit          model_valid = 1'b0;
    logic        m_hold_full = 1'b0;
    logic [15:0] m_hold = '0;
    logic [15:0] m_last = '0;
    logic [31:0] m_word = '0;
    logic [31:0] m_prev = '0;
    logic        m_fs = 1'b0;
    logic        m_ur = 1'b0;

    function automatic logic [15:0] saturate(input logic signed [16:0] s);
        int v;
        v = s;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic m_bclk();
        return ((e / int'(CLK_DIV)) % 2) == 1;
    endfunction

    function automatic int m_pos();
        int f;
        f = e / int'(2 * CLK_DIV);
        return (FRAME_BITS - 1 + f) % FRAME_BITS;
    endfunction

    function automatic logic m_data();
        int p;
        p = m_pos();
        if (p == 0) return m_prev[0];
        return m_word[FRAME_BITS - p];
    endfunction

    always @(posedge clk) begin
        logic        acc;
        logic [15:0] sv;
        int          f;
        if (rst) begin
            e = 0; m_hold_full = 1'b0; m_hold = '0; m_last = '0;
            m_word = '0; m_prev = '0; m_fs = 1'b0; m_ur = 1'b0;
            model_valid = 1'b1;
        end else begin
            acc  = sample_valid && !m_hold_full;
            sv   = saturate(sample);
            m_fs = 1'b0;
            m_ur = 1'b0;
            if (en) begin
                e = e + 1;
                if (e % int'(2 * CLK_DIV) == 0) begin
                    f = e / int'(2 * CLK_DIV);
                    if (f % FRAME_BITS == 1) begin
                        m_prev = m_word;
                        if (m_hold_full) begin
                            m_word = {m_hold, m_hold};
                            m_last = m_hold;
                            m_hold_full = 1'b0;
                        end else begin
                            m_word = {m_last, m_last};
                            m_ur = 1'b1;
                        end
                        m_fs = 1'b1;
                    end
                end
            end
            if (acc) begin
                m_hold = sv;
                m_hold_full = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check1("bclk", i2s_bclk, m_bclk());
            check1("lrclk", i2s_lrclk, m_pos() >= int'(OUT_WIDTH));
            check1("data", i2s_data, m_data());
            check1("ready", sample_ready, !m_hold_full);
            check1("frame_start", frame_start, m_fs);
            check1("underrun", underrun, m_ur);
        end
    end

    // Receiver-side capture: sample data on BCLK rise; a word completes on the first
    // left-slot bit (the previous right LSB).
    logic [31:0] cap_q[$];
    logic [31:0] sr = '0;
    logic        prev_bclk = 1'b0;
    logic        prev_lr = 1'b1;
    int          ur_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            cap_q.delete();
            sr = '0; prev_bclk = 1'b0; prev_lr = 1'b1; ur_cnt = 0;
        end else begin
            if (underrun) ur_cnt++;
            if (i2s_bclk && !prev_bclk) begin
                sr = {sr[30:0], i2s_data};
                if (!i2s_lrclk && prev_lr) cap_q.push_back(sr);
                prev_lr = i2s_lrclk;
            end
            prev_bclk = i2s_bclk;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sample_valid = 1'b0; en = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic send(input logic [16:0] s);
        int k = 0;
        sample = s;
        sample_valid = 1'b1;
        while (!sample_ready && k < 600) begin
            step(1);
            k++;
        end
        check1("send_ready", sample_ready, 1'b1);
        step(1);
        sample_valid = 1'b0;
    endtask

    task automatic wait_caps(input int n, input int budget);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check("cap_count", 32'(cap_q.size()), 32'(n));
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(17'h01111);
        step(100);
        send(17'h02222);
        step(40);
        check1("pre_reset_full", sample_ready, 1'b0);
        rst = 1'b1;
        step(1);
        check1("rst_bclk", i2s_bclk, 1'b0);
        check1("rst_lrclk", i2s_lrclk, 1'b1);
        check1("rst_data", i2s_data, 1'b0);
        check1("rst_ready", sample_ready, 1'b1);
        check1("rst_fs", frame_start, 1'b0);
        check1("rst_ur", underrun, 1'b0);
        step(1);
        check1("rst_bclk_hold1", i2s_bclk, 1'b0);
        step(1);
        check1("rst_bclk_hold2", i2s_bclk, 1'b0);
        rst = 1'b0;
        step(8);
        check1("fs_after_reset", frame_start, 1'b1);
    endtask

    task automatic single_sample_test(input logic [16:0] s, input logic [15:0] w);
        do_reset();
        step(1);
        check1("ready_c1", sample_ready, 1'b1);
        sample = s;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
        check1("ready_fall_c2", sample_ready, 1'b0);
        step(5);
        check1("fs_c7", frame_start, 1'b0);
        step(1);
        check1("fs_c8", frame_start, 1'b1);
        check1("ur_c8", underrun, 1'b0);
        check1("model_fs_pin", m_fs, 1'b1);
        step(255);
        check("ur_first_frame", 32'(ur_cnt), 32'd0);
        step(1);
        check1("fs_second", frame_start, 1'b1);
        check1("ur_second", underrun, 1'b1);
        wait_caps(3, 300);
        check("word_first", cap_q[1], {w, w});
        check("word_repeat", cap_q[2], {w, w});
    endtask

    task automatic test_saturation();
        do_reset();
        send(17'h0FFFF);
        send(17'h10000);
        send(17'h1FFFF);
        wait_caps(4, 1200);
        check("sat_pos", cap_q[1], 32'h7FFF7FFF);
        check("sat_neg", cap_q[2], 32'h80008000);
        check("sat_minus1", cap_q[3], 32'hFFFFFFFF);
        check("model_last_pin", 32'(m_last), 32'h0000FFFF);
    endtask

    task automatic test_backpressure();
        int   n_acc = 0;
        logic pr;
        do_reset();
        sample = 17'd100;
        sample_valid = 1'b1;
        pr = sample_ready;
        for (int i = 0; i < 1030; i++) begin
            step(1);
            if (pr) begin
                n_acc++;
                sample = sample + 17'sd1;
            end
            pr = sample_ready;
        end
        sample_valid = 1'b0;
        check("bp_accepts", 32'(n_acc), 32'd5);
        wait_caps(5, 300);
        check("bp_w0", cap_q[1], {16'd100, 16'd100});
        check("bp_w1", cap_q[2], {16'd101, 16'd101});
        check("bp_w2", cap_q[3], {16'd102, 16'd102});
        check("bp_w3", cap_q[4], {16'd103, 16'd103});
        check("bp_no_underrun", 32'(ur_cnt), 32'd0);
    endtask

    task automatic test_freeze();
        logic b0, l0, d0;
        do_reset();
        send(17'h05A5A);
        step(120);
        en = 1'b0;
        b0 = i2s_bclk; l0 = i2s_lrclk; d0 = i2s_data;
        send(17'h00C3C);
        check1("freeze_accept", sample_ready, 1'b0);
        for (int i = 0; i < 99; i++) begin
            step(1);
            check1("freeze_bclk", i2s_bclk, b0);
            check1("freeze_lrclk", i2s_lrclk, l0);
            check1("freeze_data", i2s_data, d0);
        end
        en = 1'b1;
        wait_caps(3, 800);
        check("freeze_w0", cap_q[1], 32'h5A5A5A5A);
        check("freeze_w1", cap_q[2], 32'h0C3C0C3C);
    endtask

    initial begin
        test_reset_mid();
        single_sample_test(17'h01234, 16'h1234);
        single_sample_test(17'h000AA, 16'h00AA);
        test_saturation();
        test_backpressure();
        test_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
